vliw_bundle_core: RTL and testbench
===================================

Name: vliw_bundle_core

Overview:
- Single-cycle VLIW core: each cycle it fetches one 320-bit bundle of ten 32-bit slots from an internal instruction memory and executes all slots in parallel.
- Contains a 32x32 register file and a word-addressed data memory.
- Instruction memory is loaded through a write port while the core is stopped.
- Top-level compute block of the design.

Parameters:
IMEM_DEPTH, 32, bundle count in instruction memory (power of 2; PC width = log2)
DMEM_DEPTH, 64, data memory words (power of 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = execute bundle at PC and advance; 0 = hold
imem_we  input  1  instruction memory write enable
imem_addr  input  log2(IMEM_DEPTH)  bundle write address
imem_wdata  input  320  bundle data; slot k = bits [32k+31:32k]
pc  output  log2(IMEM_DEPTH)  current PC
halted  output  1  last bundle executed; core stopped
dbg_reg_addr  input  5  register debug read select
dbg_reg_data  output  32  combinational R[dbg_reg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - pc=0, halted=0, every imem bundle = 0 (NOP).
  - R[i]=i for i=0..31; dmem[i]=i.
- imem write: on a clock edge with imem_we=1, imem[imem_addr]=imem_wdata. Allowed in any state.
- Execute cycle (run=1, halted=0):
  - All ten slots of imem[pc] read the register file and dmem at pre-edge values.
  - All writes commit at the same rising edge. Latency 1 cycle; results visible the following cycle.
  - pc increments by 1. If pc == IMEM_DEPTH-1, pc holds and halted=1.
- run=0 or halted=1: no state changes except imem writes.
- Slot fields: op=[31:27].
  - R-type: rs1=[26:22], rs2=[21:17], rd=[16:12].
  - MAC: rs1=[26:22], rs2=[21:17], rs3=[16:12], rd=[11:7].
  - LOAD / STORE: reg=[26:22], addr=[21:0].
  - LI: imm=[26:5] zero-extended, rd=[4:0].
- Opcodes:
  - 00000 ADD rd=rs1+rs2
  - 00001 SUB rd=rs1-rs2
  - 00010 MUL rd=low32(rs1*rs2)
  - 00011 AND
  - 00101 OR
  - 00110 XOR
  - 00100 MAC rd=low32(rs1*rs2)+rs3
  - 10010 LOAD R[reg]=dmem[addr mod DMEM_DEPTH]
  - 10011 LI rd=imm
  - 10100 STORE dmem[addr mod DMEM_DEPTH]=R[reg]
  - any other opcode: NOP
- Arithmetic: unsigned 32-bit, wrap-around, no flags.
- R0 is hard-wired to 0 (reads 0, writes ignored), so an all-zero slot is a NOP.
- Same-bundle conflicts:
  - Several slots writing the same register or dmem word: the highest-numbered slot wins.
  - LOAD and STORE to the same address in one bundle: LOAD returns the old value.
- Reset asserted mid-run: immediate return to reset state; imem contents are lost.

Optional Feature:
- Macro VLIW_DMEM_DBG_EN.
- Defined: adds ports dbg_mem_addr input log2(DMEM_DEPTH) and dbg_mem_data output 32, a combinational read of dmem.
- Undefined: these ports are absent and dmem is unobservable except through LOAD.

Test Plan:
1. Reset, then run=0 for 3 cycles.
   - pc=0, halted=0, R[i]=i.
   - A zero bundle leaves all registers unchanged.
2. Load bundle 0 = {slot9 ADD rs1=2 rs2=1 rd=3, slot7 MAC rs1=8 rs2=19 rs3=15 rd=10, slot1 LI imm=3524 rd=22, others 0}, then run.
   - After the first edge: R3=3, R10=167, R22=3524, pc=1.
3. Bundle 4 = {slot9 MUL rs1=4 rs2=2 rd=6, slot8 ADD rs1=23 rs2=2 rd=24}; bundle 13 = {slot9 ADD 2+2 rd=8, slot2 LOAD reg=4 addr=4000}.
   - After pc 4: R6=8, R24=25.
   - After pc 13: R8=4, R4=dmem[32]=32.
4. Bundle 17 = {slot9 ADD rs1=5 rs2=1 rd=4, slot0 STORE reg=8 addr=524}.
   - R4=6.
   - dmem[12]=4, checked via a subsequent LOAD or the debug port.
5. Conflict bundle {slot5 LI imm=7 rd=9, slot3 LI imm=5 rd=9}.
   - R9=7.
   - LI targeting R0 leaves R0=0.
6. Run to the end.
   - At pc=31 halted=1 and pc holds.
   - Assert rst_n=0 mid-run: pc=0 and registers return to R[i]=i immediately.

Source files
------------

// File: rtl/vliw_bundle_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vliw_bundle_core: single-cycle 10-slot VLIW core with regfile, imem, dmem. |
// | Optional: VLIW_DMEM_DBG_EN adds a combinational dmem debug read port.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vliw_bundle_core #(
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [319:0]                  imem_wdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted,
  input  logic [4:0]                    dbg_reg_addr,
  output logic [31:0]                   dbg_reg_data
`ifdef VLIW_DMEM_DBG_EN
  ,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_mem_addr,
  output logic [31:0]                   dbg_mem_data
`endif
);

  localparam int c_PCW   = $clog2(IMEM_DEPTH);
  localparam int c_DAW   = $clog2(DMEM_DEPTH);
  localparam int c_SLOTS = 10;
  localparam logic [c_PCW-1:0] c_LAST_PC = c_PCW'(IMEM_DEPTH - 1);

  localparam logic [4:0] c_OP_ADD   = 5'b00000;
  localparam logic [4:0] c_OP_SUB   = 5'b00001;
  localparam logic [4:0] c_OP_MUL   = 5'b00010;
  localparam logic [4:0] c_OP_AND   = 5'b00011;
  localparam logic [4:0] c_OP_MAC   = 5'b00100;
  localparam logic [4:0] c_OP_OR    = 5'b00101;
  localparam logic [4:0] c_OP_XOR   = 5'b00110;
  localparam logic [4:0] c_OP_LOAD  = 5'b10010;
  localparam logic [4:0] c_OP_LI    = 5'b10011;
  localparam logic [4:0] c_OP_STORE = 5'b10100;

  logic [319:0]     imem_q [IMEM_DEPTH];
  logic [31:0]      rf_q   [32];
  logic [31:0]      rf_d   [32];
  logic [31:0]      dmem_q [DMEM_DEPTH];
  logic [31:0]      dmem_d [DMEM_DEPTH];
  logic [c_PCW-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;

  logic [319:0]     w_bundle;
  logic             w_exec;
  logic [c_SLOTS-1:0] w_rf_we;
  logic [c_SLOTS-1:0] w_dm_we;
  logic [4:0]       w_rf_wa [c_SLOTS];
  logic [31:0]      w_rf_wv [c_SLOTS];
  logic [c_DAW-1:0] w_dm_wa [c_SLOTS];
  logic [31:0]      w_dm_wv [c_SLOTS];

  assign w_bundle = imem_q[pc_q];
  assign w_exec   = run & ~halted_q;

  // Each slot decodes independently against pre-edge register/dmem state.
  generate
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
      logic [31:0] w_slot;
      logic [4:0]  w_op;
      logic [31:0] w_a, w_b, w_c, w_prod;
      logic        w_we, w_se;
      logic [4:0]  w_wa;
      logic [31:0] w_wv;

      assign w_slot = w_bundle[32*k +: 32];
      assign w_op   = w_slot[31:27];
      assign w_a    = rf_q[w_slot[26:22]];
      assign w_b    = rf_q[w_slot[21:17]];
      assign w_c    = rf_q[w_slot[16:12]];
      assign w_prod = w_a * w_b;

      always_comb begin
        w_we = 1'b0;
        w_se = 1'b0;
        w_wa = w_slot[16:12];
        w_wv = '0;
        case (w_op)
          c_OP_ADD: begin w_we = 1'b1; w_wv = w_a + w_b; end
          c_OP_SUB: begin w_we = 1'b1; w_wv = w_a - w_b; end
          c_OP_MUL: begin w_we = 1'b1; w_wv = w_prod; end
          c_OP_AND: begin w_we = 1'b1; w_wv = w_a & w_b; end
          c_OP_OR:  begin w_we = 1'b1; w_wv = w_a | w_b; end
          c_OP_XOR: begin w_we = 1'b1; w_wv = w_a ^ w_b; end
          c_OP_MAC: begin
            w_we = 1'b1;
            w_wa = w_slot[11:7];
            w_wv = w_prod + w_c;
          end
          c_OP_LOAD: begin
            w_we = 1'b1;
            w_wa = w_slot[26:22];
            w_wv = dmem_q[w_slot[c_DAW-1:0]];
          end
          c_OP_LI: begin
            w_we = 1'b1;
            w_wa = w_slot[4:0];
            w_wv = {10'd0, w_slot[26:5]};
          end
          c_OP_STORE: w_se = 1'b1;
          default: ;
        endcase
      end

      assign w_rf_we[k] = w_we;
      assign w_rf_wa[k] = w_wa;
      assign w_rf_wv[k] = w_wv;
      assign w_dm_we[k] = w_se;
      assign w_dm_wa[k] = w_slot[c_DAW-1:0];
      assign w_dm_wv[k] = w_a;
    end
  endgenerate

  // Slots applied in ascending order so the highest-numbered writer wins.
  always_comb begin
    rf_d     = rf_q;
    dmem_d   = dmem_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (w_exec) begin
      for (int k = 0; k < c_SLOTS; k++) begin
        if (w_rf_we[k]) rf_d[w_rf_wa[k]] = w_rf_wv[k];
        if (w_dm_we[k]) dmem_d[w_dm_wa[k]] = w_dm_wv[k];
      end
      rf_d[0] = '0;
      if (pc_q == c_LAST_PC) halted_d = 1'b1;
      else                   pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++)         rf_q[i]   <= 32'(i);
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'(i);
      for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      rf_q     <= rf_d;
      dmem_q   <= dmem_d;
      if (imem_we) imem_q[imem_addr] <= imem_wdata;
    end
  end

  assign pc           = pc_q;
  assign halted       = halted_q;
  assign dbg_reg_data = rf_q[dbg_reg_addr];

`ifdef VLIW_DMEM_DBG_EN
  assign dbg_mem_data = dmem_q[dbg_mem_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_vliw_bundle_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vliw_bundle_core: directed + random bench with a behavioural ISA model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vliw_bundle_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         run;
  logic         imem_we;
  logic [4:0]   imem_addr;
  logic [319:0] imem_wdata;
  logic [4:0]   pc;
  logic         halted;
  logic [4:0]   dbg_reg_addr;
  logic [31:0]  dbg_reg_data;
`ifdef VLIW_DMEM_DBG_EN
  logic [5:0]   dbg_mem_addr;
  logic [31:0]  dbg_mem_data;
`endif

  vliw_bundle_core #(.IMEM_DEPTH(32), .DMEM_DEPTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .pc           (pc),
    .halted       (halted),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
`ifdef VLIW_DMEM_DBG_EN
    ,
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem_data (dbg_mem_data)
`endif
  );

  always #100 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0]  m_rf [32];
  logic [31:0]  m_dm [64];
  logic [319:0] m_im [32];
  int           m_pc;
  bit           m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] val);
    dbg_reg_addr = 5'(idx);
    #1;
    val = dbg_reg_data;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] v;
    check($sformatf("%s.pc", tag), 32'(pc), 32'(m_pc));
    check($sformatf("%s.halted", tag), 32'(halted), 32'(m_halt));
    for (int i = 0; i < 32; i++) begin
      rd_reg(i, v);
      check($sformatf("%s.R%0d", tag, i), v, m_rf[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
    for (int i = 0; i < 64; i++) m_dm[i] = 32'(i);
    for (int i = 0; i < 32; i++) m_im[i] = '0;
    m_pc   = 0;
    m_halt = 1'b0;
  endtask

  // Architectural semantics: every slot reads the old state; later slots
  // overwrite earlier ones in the new state.
  task automatic model_step();
    logic [31:0]  nrf [32];
    logic [31:0]  ndm [64];
    logic [319:0] b;
    logic [31:0]  s, x, y, z;
    int           a;
    if (run && !m_halt) begin
      nrf = m_rf;
      ndm = m_dm;
      b   = m_im[m_pc];
      for (int k = 0; k < 10; k++) begin
        s = b[32*k +: 32];
        x = m_rf[s[26:22]];
        y = m_rf[s[21:17]];
        z = m_rf[s[16:12]];
        a = int'(s[21:0]) % 64;
        case (s[31:27])
          5'd0:  nrf[s[16:12]] = x + y;
          5'd1:  nrf[s[16:12]] = x - y;
          5'd2:  nrf[s[16:12]] = x * y;
          5'd3:  nrf[s[16:12]] = x & y;
          5'd5:  nrf[s[16:12]] = x | y;
          5'd6:  nrf[s[16:12]] = x ^ y;
          5'd4:  nrf[s[11:7]]  = x * y + z;
          5'd18: nrf[s[26:22]] = m_dm[a];
          5'd19: nrf[s[4:0]]   = 32'(s[26:5]);
          5'd20: ndm[a]        = x;
          default: ;
        endcase
      end
      nrf[0] = '0;
      m_rf = nrf;
      m_dm = ndm;
      if (m_pc == 31) m_halt = 1'b1;
      else            m_pc++;
    end
    if (imem_we) m_im[imem_addr] = imem_wdata;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd);
    return {op, rs1, rs2, rd, 12'd0};
  endfunction
  function automatic logic [31:0] enc_mac(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rs3, input logic [4:0] rd);
    return {5'b00100, rs1, rs2, rs3, rd, 7'd0};
  endfunction
  function automatic logic [31:0] enc_mem(input logic [4:0] op, input logic [4:0] r,
                                          input logic [21:0] addr);
    return {op, r, addr};
  endfunction
  function automatic logic [31:0] enc_li(input logic [21:0] imm, input logic [4:0] rd);
    return {5'b10011, imm, rd};
  endfunction

  task automatic rand_slot(output logic [31:0] s);
    logic [4:0]  ops [11];
    logic [31:0] r;
    logic [21:0] ad;
    int          sel;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd4, 5'd18, 5'd19, 5'd20, 5'd0};
    sel = int'($urandom_range(0, 10));
    r   = $urandom;
    s   = r;
    s[31:27] = (sel == 10) ? 5'($urandom_range(0, 31)) : ops[sel];
    if (s[31:27] == 5'd18 || s[31:27] == 5'd20) begin
      ad = r[21:0];
      if ($urandom_range(0, 1) == 1) ad[5:0] = 6'($urandom_range(0, 3));
      s[21:0] = ad;
    end
  endtask

  task automatic rand_bundle(output logic [319:0] b);
    logic [31:0] s;
    for (int k = 0; k < 10; k++) begin
      rand_slot(s);
      b[32*k +: 32] = ($urandom_range(0, 4) == 0) ? 32'd0 : s;
    end
  endtask

  task automatic load_bundle(input int addr, input logic [319:0] b);
    imem_we    = 1'b1;
    imem_addr  = 5'(addr);
    imem_wdata = b;
    cycle();
    imem_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [319:0] b;
    logic [31:0]  v;
    int           pre;
    int           guard;

    rst_n = 1'b0; run = 1'b0; imem_we = 1'b0; imem_addr = '0;
    imem_wdata = '0; dbg_reg_addr = '0;
`ifdef VLIW_DMEM_DBG_EN
    dbg_mem_addr = '0;
`endif
    @(negedge clk);
    do_reset();
    compare_all("reset");

    for (int c = 0; c < 3; c++) begin
      cycle();
      compare_all($sformatf("idle%0d", c));
    end

    b = '0;
    b[32*9 +: 32] = enc_r(5'd0, 5'd2, 5'd1, 5'd3);
    b[32*7 +: 32] = enc_mac(5'd8, 5'd19, 5'd15, 5'd10);
    b[32*1 +: 32] = enc_li(22'd3524, 5'd22);
    load_bundle(0, b);
    b = '0;
    b[32*9 +: 32] = enc_r(5'd2, 5'd4, 5'd2, 5'd6);
    b[32*8 +: 32] = enc_r(5'd0, 5'd23, 5'd2, 5'd24);
    load_bundle(4, b);
    b = '0;
    b[32*9 +: 32] = enc_r(5'd0, 5'd2, 5'd2, 5'd8);
    b[32*2 +: 32] = enc_mem(5'd18, 5'd4, 22'd4000);
    load_bundle(13, b);
    b = '0;
    b[32*9 +: 32] = enc_r(5'd0, 5'd5, 5'd1, 5'd4);
    b[32*0 +: 32] = enc_mem(5'd20, 5'd8, 22'd524);
    load_bundle(17, b);
    b = '0;
    b[32*0 +: 32] = enc_mem(5'd18, 5'd11, 22'd12);
    load_bundle(18, b);
    b = '0;
    b[32*5 +: 32] = enc_li(22'd7, 5'd9);
    b[32*3 +: 32] = enc_li(22'd5, 5'd9);
    b[32*6 +: 32] = enc_li(22'd99, 5'd0);
    load_bundle(20, b);
    compare_all("loaded");

    run = 1'b1;
    guard = 0;
    while (!m_halt && guard < 40) begin
      pre = m_pc;
      cycle();
      compare_all($sformatf("dir_pc%0d", pre));
      case (pre)
        0: begin
          check("t2.pc", 32'(pc), 32'd1);
          rd_reg(3, v);  check("t2.R3", v, 32'd3);
          rd_reg(10, v); check("t2.R10", v, 32'd167);
          rd_reg(22, v); check("t2.R22", v, 32'd3524);
        end
        4: begin
          rd_reg(6, v);  check("t3.R6", v, 32'd8);
          rd_reg(24, v); check("t3.R24", v, 32'd25);
        end
        13: begin
          rd_reg(8, v); check("t3.R8", v, 32'd4);
          rd_reg(4, v); check("t3.R4", v, 32'd32);
        end
        17: begin rd_reg(4, v); check("t4.R4", v, 32'd6); end
        18: begin rd_reg(11, v); check("t4.dmem12", v, 32'd4); end
        20: begin
          rd_reg(9, v); check("t5.R9", v, 32'd7);
          rd_reg(0, v); check("t5.R0", v, 32'd0);
        end
        default: ;
      endcase
      guard++;
    end
    check("t6.halted", 32'(halted), 32'd1);
    for (int c = 0; c < 2; c++) begin
      cycle();
      check($sformatf("t6.pc_hold%0d", c), 32'(pc), 32'd31);
      check($sformatf("t6.halt_hold%0d", c), 32'(halted), 32'd1);
    end

    run = 1'b0;
    do_reset();
    compare_all("rnd_reset");
    for (int i = 0; i < 32; i++) begin
      rand_bundle(b);
      load_bundle(i, b);
    end
    guard = 0;
    while (!m_halt && guard < 80) begin
      run     = ($urandom_range(0, 3) != 0);
      imem_we = ($urandom_range(0, 7) == 0);
      imem_addr = 5'($urandom_range(0, 31));
      rand_bundle(imem_wdata);
      cycle();
      compare_all($sformatf("rnd%0d", guard));
      guard++;
    end
    imem_we = 1'b0;
    check("rnd.halted", 32'(halted), 32'd1);

    run = 1'b0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rand_bundle(b);
      load_bundle(i, b);
    end
    run = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    compare_all("pre_midrst");
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      compare_all($sformatf("post_rst%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
